// File: rtl/datapath_mc_pkg.sv
// Shared definitions for the multicycle datapath: instruction field
// positions, ALU operation codes and sequencer states.
package datapath_mc_pkg;

  // Instruction word layout (9 bits): [8:5] opcode, [4:3] rA, [2:1] rB,
  // [2:0] immediate, [0] function bit, [4:0] branch-target LUT index.
  localparam int IR_W      = 9;
  localparam int OPCODE_W  = 4;
  localparam int OP_LSB    = 5;
  localparam int REG_SEL_W = 2;
  localparam int RA_LSB    = 3;
  localparam int RB_LSB    = 1;
  localparam int IMM_W     = 3;
  localparam int FC_BIT    = 0;
  localparam int BIDX_W    = 5;
  localparam int NUM_REGS  = 4;

  typedef enum logic [2:0] {
    ALU_ADD   = 3'd0,
    ALU_SUB   = 3'd1,
    ALU_AND   = 3'd2,
    ALU_OR    = 3'd3,
    ALU_XOR   = 3'd4,
    ALU_SHL   = 3'd5,
    ALU_SHR   = 3'd6,
    ALU_PASSB = 3'd7
  } alu_op_t;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_EXEC  = 3'd2,
    S_MEM   = 3'd3,
    S_HALT  = 3'd4,
    S_FAULT = 3'd5
  } state_t;

endpackage

// File: rtl/datapath_mc_if.sv
// Data-memory request/acknowledge bus between the datapath (master) and
// the data memory (slave). Address and data are DW bits wide.
interface datapath_mc_if #(
  parameter int DW = 8
) ();

  logic          dmem_req;
  logic          dmem_we;
  logic [DW-1:0] dmem_addr;
  logic [DW-1:0] dmem_wdata;
  logic [DW-1:0] dmem_rdata;
  logic          dmem_ack;

  modport master (
    output dmem_req,
    output dmem_we,
    output dmem_addr,
    output dmem_wdata,
    input  dmem_rdata,
    input  dmem_ack
  );

  modport slave (
    input  dmem_req,
    input  dmem_we,
    input  dmem_addr,
    input  dmem_wdata,
    output dmem_rdata,
    output dmem_ack
  );

endinterface

// File: rtl/datapath_mc_alu_p.sv
// Combinational DW-bit ALU. Carry/borrow only comes from ADD/SUB (zero
// otherwise); the shift flag S only changes on shifts and is passed
// through unchanged for every other operation.
module alu_p
  import datapath_mc_pkg::*;
#(
  parameter int DW = 8
) (
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  input  alu_op_t       op,
  input  logic          sc_in,
  input  logic          s_in,
  output logic [DW-1:0] out,
  output logic          c_out,
  output logic          s_out,
  output logic          zero
);

  logic [DW:0] sum;
  logic [DW:0] diff;

  // One extra bit catches the carry out of ADD and the borrow of SUB.
  assign sum  = {1'b0, a} + {1'b0, b} + {{DW{1'b0}}, sc_in};
  assign diff = {1'b0, a} - {1'b0, b};

  // Operation select; defaults keep C cleared and S unchanged.
  always_comb begin
    out   = '0;
    c_out = 1'b0;
    s_out = s_in;
    case (op)
      ALU_ADD: begin
        out   = sum[DW-1:0];
        c_out = sum[DW];
      end
      ALU_SUB: begin
        out   = diff[DW-1:0];
        c_out = diff[DW];
      end
      ALU_AND: out = a & b;
      ALU_OR:  out = a | b;
      ALU_XOR: out = a ^ b;
      ALU_SHL: begin
        out   = {a[DW-2:0], s_in};
        s_out = a[DW-1];
      end
      ALU_SHR: begin
        out   = {s_in, a[DW-1:1]};
        s_out = a[0];
      end
      default: out = b;
    endcase
  end

  assign zero = (out == '0);

endmodule

// File: rtl/datapath_mc.sv
// Multicycle 9-bit-instruction datapath. A FETCH/EXEC/MEM sequencer lets
// the data memory take any number of cycles to acknowledge, with a
// watchdog that parks the machine in FAULT if the ack never comes.
module datapath_mc
  import datapath_mc_pkg::*;
#(
  parameter int DW      = 8,
  parameter int PCW     = 16,
  parameter int TIMEOUT = 16
) (
  input  logic                CLK,
  input  logic                reset_n,
  input  logic                START,
  output logic [PCW-1:0]      imem_addr,
  input  logic [IR_W-1:0]     imem_data,
  output logic [OPCODE_W-1:0] opcode,
  output logic                fcode,
  output logic [BIDX_W-1:0]   br_idx,
  input  logic [PCW-1:0]      br_target,
  input  logic                CTRL_branch_rel_nz,
  input  logic                CTRL_branch_rel_z,
  input  logic                CTRL_branch_abs,
  input  logic                CTRL_reg_write_en,
  input  logic                CTRL_mem_to_reg,
  input  logic                CTRL_alu_src,
  input  logic                CTRL_alu_sc_in,
  input  logic                CTRL_read_mem,
  input  logic                CTRL_write_mem,
  input  logic                CTRL_flag_we,
  input  logic                CTRL_halt,
  input  alu_op_t             CTRL_alu_op,
  datapath_mc_if.master       dmem,
  output logic                DONE,
  output logic                FAULT
);

  // Counter just wide enough to hold TIMEOUT-1.
  localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [CW-1:0] CNT_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  state_t                 state_reg, state_next;
  logic [PCW-1:0]         pc_reg, pc_next;
  logic [IR_W-1:0]        ir_reg;
  logic [DW-1:0]          regs [NUM_REGS];
  logic                   flag_z_reg, flag_c_reg, flag_s_reg;
  logic [CW-1:0]          cnt_reg, cnt_next;
  logic                   done_reg;

  logic                   ir_load;
  logic                   reg_we;
  logic [DW-1:0]          reg_wdata;
  logic                   flag_we;

  logic [REG_SEL_W-1:0]   ra, rb;
  logic [DW-1:0]          imm;
  logic [DW-1:0]          op_a, op_b;
  logic [DW-1:0]          alu_out;
  logic                   alu_c, alu_s, alu_zero;
  logic                   mem_op;
  logic                   take_rel;
  logic [PCW-1:0]         branch_pc;

  // Instruction field decode from the held IR.
  assign ra     = ir_reg[RA_LSB +: REG_SEL_W];
  assign rb     = ir_reg[RB_LSB +: REG_SEL_W];
  assign imm    = {{(DW-IMM_W){1'b0}}, ir_reg[0 +: IMM_W]};
  assign opcode = ir_reg[OP_LSB +: OPCODE_W];
  assign fcode  = ir_reg[FC_BIT];
  assign br_idx = ir_reg[0 +: BIDX_W];

  assign op_a   = regs[ra];
  assign op_b   = CTRL_alu_src ? imm : regs[rb];
  assign mem_op = CTRL_read_mem | CTRL_write_mem;

  alu_p #(.DW(DW)) u_alu (
    .a     (op_a),
    .b     (op_b),
    .op    (CTRL_alu_op),
    .sc_in (CTRL_alu_sc_in),
    .s_in  (flag_s_reg),
    .out   (alu_out),
    .c_out (alu_c),
    .s_out (alu_s),
    .zero  (alu_zero)
  );

  // Relative branches test the stored Z flag, never the current ALU result.
  assign take_rel  = (CTRL_branch_rel_z & flag_z_reg) | (CTRL_branch_rel_nz & ~flag_z_reg);
  assign branch_pc = CTRL_branch_abs ? br_target :
                     take_rel        ? pc_reg + br_target :
                                       pc_reg + 1'b1;

  // Sequencer next state plus the per-state write enables it controls.
  always_comb begin
    state_next = state_reg;
    pc_next    = pc_reg;
    cnt_next   = cnt_reg;
    ir_load    = 1'b0;
    reg_we     = 1'b0;
    reg_wdata  = alu_out;
    flag_we    = 1'b0;
    if (START) begin
      state_next = S_FETCH;
      pc_next    = '0;
      cnt_next   = '0;
    end else begin
      case (state_reg)
        S_FETCH: begin
          ir_load    = 1'b1;
          state_next = S_EXEC;
        end
        S_EXEC: begin
          if (CTRL_halt) begin
            state_next = S_HALT;
          end else if (mem_op) begin
            cnt_next   = '0;
            state_next = S_MEM;
          end else begin
            reg_we     = CTRL_reg_write_en;
            flag_we    = CTRL_flag_we;
            pc_next    = branch_pc;
            state_next = S_FETCH;
          end
        end
        S_MEM: begin
          // An ack in the watchdog's last cycle still completes the access.
          if (dmem.dmem_ack) begin
            reg_we     = CTRL_read_mem & CTRL_mem_to_reg & CTRL_reg_write_en;
            reg_wdata  = dmem.dmem_rdata;
            pc_next    = pc_reg + 1'b1;
            state_next = S_FETCH;
          end else if ((TIMEOUT != 0) && (cnt_reg == CNT_LAST)) begin
            state_next = S_FAULT;
          end else begin
            cnt_next = cnt_reg + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Sequencer state, PC, watchdog counter and the registered DONE flag.
  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      state_reg <= S_IDLE;
      pc_reg    <= '0;
      cnt_reg   <= '0;
      done_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      pc_reg    <= pc_next;
      cnt_reg   <= cnt_next;
      done_reg  <= (state_next == S_HALT) || (state_next == S_FAULT);
    end
  end

  // Instruction register, loaded only during FETCH.
  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      ir_reg <= '0;
    end else if (ir_load) begin
      ir_reg <= imem_data;
    end
  end

  // Register file; the single write port always targets rA. START leaves it alone.
  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
    end else if (reg_we) begin
      regs[ra] <= reg_wdata;
    end
  end

  // Z/C/S flags: cleared by START, otherwise written by non-memory EXEC.
  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      flag_z_reg <= 1'b0;
      flag_c_reg <= 1'b0;
      flag_s_reg <= 1'b0;
    end else if (START) begin
      flag_z_reg <= 1'b0;
      flag_c_reg <= 1'b0;
      flag_s_reg <= 1'b0;
    end else if (flag_we) begin
      flag_z_reg <= alu_zero;
      flag_c_reg <= alu_c;
      flag_s_reg <= alu_s;
    end
  end

  assign imem_addr       = pc_reg;
  assign dmem.dmem_req   = (state_reg == S_MEM);
  assign dmem.dmem_we    = (state_reg == S_MEM) & CTRL_write_mem;
  assign dmem.dmem_addr  = regs[rb];
  assign dmem.dmem_wdata = regs[ra];
  assign DONE            = done_reg;
  assign FAULT           = (state_reg == S_FAULT);

endmodule

// File: tb/tb_datapath_mc.sv
// Bench for datapath_mc: directed scenarios followed by random instruction
// streams, all checked against an arithmetic model of the instruction set.
module tb_datapath_mc;
  import datapath_mc_pkg::*;

  localparam int DW      = 8;
  localparam int PCW     = 16;
  localparam int TIMEOUT = 4;
  localparam int M       = 1 << DW;
  localparam int PM      = 1 << PCW;

  typedef struct packed {
    logic    rel_nz, rel_z, br_abs, rwe, m2r, alu_src, sc_in, rd, wr, fwe, halt;
    alu_op_t op;
  } ctrl_t;

  logic           CLK = 1'b0;
  logic           reset_n = 1'b0;
  logic           START = 1'b0;
  logic [PCW-1:0] imem_addr;
  logic [8:0]     imem_data = '0;
  logic [3:0]     opcode;
  logic           fcode;
  logic [4:0]     br_idx;
  logic [PCW-1:0] br_target = '0;
  logic           DONE, FAULT;
  ctrl_t          cur = '0;

  datapath_mc_if #(.DW(DW)) dmem ();

  datapath_mc #(.DW(DW), .PCW(PCW), .TIMEOUT(TIMEOUT)) dut (
    .CLK(CLK), .reset_n(reset_n), .START(START),
    .imem_addr(imem_addr), .imem_data(imem_data),
    .opcode(opcode), .fcode(fcode), .br_idx(br_idx), .br_target(br_target),
    .CTRL_branch_rel_nz(cur.rel_nz), .CTRL_branch_rel_z(cur.rel_z),
    .CTRL_branch_abs(cur.br_abs), .CTRL_reg_write_en(cur.rwe),
    .CTRL_mem_to_reg(cur.m2r), .CTRL_alu_src(cur.alu_src),
    .CTRL_alu_sc_in(cur.sc_in), .CTRL_read_mem(cur.rd),
    .CTRL_write_mem(cur.wr), .CTRL_flag_we(cur.fwe), .CTRL_halt(cur.halt),
    .CTRL_alu_op(cur.op), .dmem(dmem), .DONE(DONE), .FAULT(FAULT)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  // Reference model state.
  int m_reg [4];
  int m_z, m_c, m_s, m_pc;
  int m_done, m_fault;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic ctrl_t mk(alu_op_t op, bit rwe, bit fwe, bit src);
    ctrl_t c = '0;
    c.op = op; c.rwe = rwe; c.fwe = fwe; c.alu_src = src;
    return c;
  endfunction

  function automatic ctrl_t ld_c();
    ctrl_t c = '0;
    c.rd = 1'b1; c.m2r = 1'b1; c.rwe = 1'b1;
    return c;
  endfunction

  function automatic logic [8:0] enc(int opc, int ra, int low);
    return {opc[3:0], ra[1:0], low[2:0]};
  endfunction

  // Instruction-set level ALU: plain integer arithmetic modulo 2^DW.
  function automatic void alu_model(input alu_op_t op, input int a, input int b, input int sc,
                                    input int s, output int out, output int c, output int so);
    c  = 0;
    so = s;
    case (op)
      ALU_ADD: begin out = a + b + sc; c = (out >= M) ? 1 : 0; out = out % M; end
      ALU_SUB: begin c = (a < b) ? 1 : 0; out = (a - b + M) % M; end
      ALU_AND: out = a & b;
      ALU_OR:  out = a | b;
      ALU_XOR: out = a ^ b;
      ALU_SHL: begin out = (a * 2 + s) % M; so = a / (M / 2); end
      ALU_SHR: begin out = a / 2 + s * (M / 2); so = a % 2; end
      default: out = b;
    endcase
  endfunction

  task automatic check_all(input string tag);
    chk({tag, "_pc"}, imem_addr, m_pc);
    for (int i = 0; i < 4; i++) chk($sformatf("%s_r%0d", tag, i), dut.regs[i], m_reg[i]);
    chk({tag, "_z"}, dut.flag_z_reg, m_z);
    chk({tag, "_c"}, dut.flag_c_reg, m_c);
    chk({tag, "_s"}, dut.flag_s_reg, m_s);
    chk({tag, "_done"}, DONE, m_done);
    chk({tag, "_fault"}, FAULT, m_fault);
    chk({tag, "_req"}, dmem.dmem_req, 0);
  endtask

  task automatic model_start();
    m_pc = 0; m_z = 0; m_c = 0; m_s = 0; m_done = 0; m_fault = 0;
  endtask

  task automatic pulse_start();
    START = 1'b1;
    @(negedge CLK);
    START = 1'b0;
    model_start();
  endtask

  // Runs one instruction starting from FETCH; ack_at = MEM cycle of the ack (0 = never).
  task automatic run(input logic [8:0] ir, input ctrl_t c, input logic [PCW-1:0] tgt,
                     input int ack_at, input logic [DW-1:0] rdata, output int cycles);
    int ra, rb, a, b, res, co, so, k;
    bit fin;
    ra = int'(ir[4:3]);
    rb = int'(ir[2:1]);
    imem_data = ir; cur = c; br_target = tgt; cycles = 0;
    @(negedge CLK); cycles++;
    chk("opcode", opcode, ir[8:5]);
    chk("fcode", fcode, ir[0]);
    chk("br_idx", br_idx, ir[4:0]);
    if (c.halt) begin
      @(negedge CLK); cycles++;
      m_done = 1;
    end else if (c.rd || c.wr) begin
      @(negedge CLK); cycles++;
      fin = 1'b0;
      k = 1;
      while (!fin) begin
        chk("mem_req", dmem.dmem_req, 1);
        chk("mem_we", dmem.dmem_we, c.wr);
        chk("mem_addr", dmem.dmem_addr, m_reg[rb]);
        chk("mem_wdata", dmem.dmem_wdata, m_reg[ra]);
        dmem.dmem_ack = (k == ack_at);
        dmem.dmem_rdata = rdata;
        @(negedge CLK); cycles++;
        dmem.dmem_ack = 1'b0;
        if (k == ack_at) begin
          fin = 1'b1;
          if (c.rd && c.m2r && c.rwe) m_reg[ra] = int'(rdata);
          m_pc = (m_pc + 1) % PM;
        end else if (k == TIMEOUT) begin
          fin = 1'b1;
          m_fault = 1;
          m_done = 1;
        end
        k++;
      end
    end else begin
      a = m_reg[ra];
      b = c.alu_src ? int'(ir[2:0]) : m_reg[rb];
      alu_model(c.op, a, b, int'(c.sc_in), m_s, res, co, so);
      if (c.br_abs) m_pc = int'(tgt);
      else if ((c.rel_z && m_z != 0) || (c.rel_nz && m_z == 0)) m_pc = (m_pc + int'(tgt)) % PM;
      else m_pc = (m_pc + 1) % PM;
      if (c.rwe) m_reg[ra] = res;
      if (c.fwe) begin m_z = (res == 0) ? 1 : 0; m_c = co; m_s = so; end
      @(negedge CLK); cycles++;
    end
    check_all("post");
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    ctrl_t c;
    int cyc, kind, sel, ack;
    logic [31:0] rnd;

    dmem.dmem_ack = 1'b0;
    dmem.dmem_rdata = '0;
    for (int i = 0; i < 4; i++) m_reg[i] = 0;
    model_start();

    // Reset state.
    repeat (2) @(negedge CLK);
    chk("rst_opcode", opcode, 0);
    chk("rst_we", dmem.dmem_we, 0);
    chk("rst_addr", dmem.dmem_addr, 0);
    chk("rst_wdata", dmem.dmem_wdata, 0);
    check_all("reset");
    reset_n = 1'b1;
    repeat (2) @(negedge CLK);
    chk("idle_state", dut.state_reg, S_IDLE);
    chk("idle_pc", imem_addr, 0);
    pulse_start();
    chk("start_fetch", dut.state_reg, S_FETCH);

    // Loads set R0=0xF0 and R1=0x20; the second acks in the watchdog's last cycle.
    run(enc(1, 0, 0), ld_c(), 16'h0, 1, 8'hF0, cyc);
    chk("ld1_cycles", cyc, 3);
    run(enc(1, 1, 0), ld_c(), 16'h0, TIMEOUT, 8'h20, cyc);
    chk("ack_wins_cycles", cyc, 2 + TIMEOUT);
    chk("ack_wins_fault", FAULT, 0);

    // ADD R0,R1 with flags.
    run(enc(2, 0, 2), mk(ALU_ADD, 1, 1, 0), 16'h0, 0, 0, cyc);
    chk("add_r0", dut.regs[0], 8'h10);
    chk("add_c", dut.flag_c_reg, 1);
    chk("add_z", dut.flag_z_reg, 0);
    chk("add_cycles", cyc, 2);
    chk("add_pc", imem_addr, 3);

    // Branches: Z=1 then rel_z back by 3, Z=0 falls through, then absolute.
    run(enc(3, 2, 4), mk(ALU_XOR, 1, 1, 0), 16'h0, 0, 0, cyc);
    chk("xor_z", dut.flag_z_reg, 1);
    c = mk(ALU_PASSB, 0, 0, 0); c.br_abs = 1'b1;
    run(enc(7, 0, 0), c, 16'h0005, 0, 0, cyc);
    c = mk(ALU_PASSB, 0, 0, 0); c.rel_z = 1'b1;
    run(enc(8, 0, 0), c, 16'hFFFD, 0, 0, cyc);
    chk("relz_taken_pc", imem_addr, 16'h0002);
    run(enc(4, 3, 1), mk(ALU_PASSB, 1, 1, 1), 16'h0, 0, 0, cyc);
    c = mk(ALU_PASSB, 0, 0, 0); c.br_abs = 1'b1;
    run(enc(7, 0, 0), c, 16'h0005, 0, 0, cyc);
    c = mk(ALU_PASSB, 0, 0, 0); c.rel_z = 1'b1;
    run(enc(8, 0, 0), c, 16'hFFFD, 0, 0, cyc);
    chk("relz_not_taken_pc", imem_addr, 16'h0006);
    c = mk(ALU_PASSB, 0, 0, 0); c.br_abs = 1'b1;
    run(enc(7, 0, 0), c, 16'h0040, 0, 0, cyc);
    chk("abs_pc", imem_addr, 16'h0040);

    // Load acked in 3rd MEM cycle; flag_we must not touch flags on a memory op.
    c = ld_c(); c.fwe = 1'b1; c.op = ALU_ADD;
    run(enc(1, 2, 0), c, 16'h0, 3, 8'h5A, cyc);
    chk("ld3_r2", dut.regs[2], 8'h5A);
    chk("ld3_cycles", cyc, 5);
    c = '0; c.wr = 1'b1;
    run(enc(9, 2, 0), c, 16'h0, 2, 8'h00, cyc);

    // PC wraps modulo 2^PCW.
    c = mk(ALU_PASSB, 0, 0, 0); c.br_abs = 1'b1;
    run(enc(7, 0, 0), c, 16'hFFFF, 0, 0, cyc);
    run(enc(5, 0, 0), mk(ALU_PASSB, 0, 0, 0), 16'h0, 0, 0, cyc);
    chk("pc_wrap", imem_addr, 0);

    // Watchdog: no ack, then a late ack that must be ignored, then START.
    run(enc(1, 3, 0), ld_c(), 16'h0, 0, 8'hAA, cyc);
    chk("to_cycles", cyc, 2 + TIMEOUT);
    chk("to_fault", FAULT, 1);
    dmem.dmem_ack = 1'b1; dmem.dmem_rdata = 8'hEE;
    @(negedge CLK);
    dmem.dmem_ack = 1'b0;
    check_all("late_ack");
    chk("late_ack_state", dut.state_reg, S_FAULT);
    pulse_start();
    check_all("fault_restart");

    // Halt: no side effects, DONE held, PC frozen.
    c = mk(ALU_ADD, 1, 1, 0); c.halt = 1'b1;
    run(enc(6, 0, 2), c, 16'h0, 0, 0, cyc);
    chk("halt_cycles", cyc, 2);
    repeat (3) @(negedge CLK);
    check_all("halt_hold");
    pulse_start();
    check_all("halt_restart");

    // Asynchronous reset in the middle of a memory access.
    imem_data = enc(1, 0, 0); cur = ld_c();
    repeat (2) @(negedge CLK);
    chk("pre_rst_req", dmem.dmem_req, 1);
    #2 reset_n = 1'b0;
    #1;
    for (int i = 0; i < 4; i++) m_reg[i] = 0;
    model_start();
    chk("rst_mid_req", dmem.dmem_req, 0);
    chk("rst_mid_pc", imem_addr, 0);
    chk("rst_mid_done", DONE, 0);
    @(negedge CLK);
    reset_n = 1'b1;
    @(negedge CLK);
    chk("rst_idle", dut.state_reg, S_IDLE);
    pulse_start();
    chk("rst_start_fetch", dut.state_reg, S_FETCH);
    imem_data = enc(5, 1, 2); cur = mk(ALU_PASSB, 0, 0, 0);
    @(negedge CLK);
    chk("rst_start_exec", dut.state_reg, S_EXEC);
    @(negedge CLK);
    m_pc = 1;
    check_all("post_rst");

    // Random instruction stream.
    for (int n = 0; n < 200; n++) begin
      rnd = $urandom;
      c = '0;
      c.op      = alu_op_t'(rnd[2:0]);
      c.sc_in   = rnd[3];
      c.alu_src = rnd[4];
      c.rwe     = rnd[5];
      c.fwe     = rnd[6];
      c.m2r     = rnd[7];
      ack = 0;
      kind = int'($urandom_range(0, 9));
      if (kind < 3) begin
        if (rnd[8]) c.rd = 1'b1; else c.wr = 1'b1;
        ack = int'($urandom_range(1, TIMEOUT));
      end else begin
        sel = int'($urandom_range(0, 5));
        if (sel == 0) c.br_abs = 1'b1;
        else if (sel == 1) c.rel_z = 1'b1;
        else if (sel == 2) c.rel_nz = 1'b1;
      end
      run(rnd[17:9], c, rnd[31:16], ack, 8'($urandom), cyc);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
